// File: rtl/ddr3_line_cache_pkg.sv
// Shared types for the direct-mapped write-back line cache: FSM encoding and byte-lane merge.
package ddr3_line_cache_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOOKUP = 4'd1,
    ST_EVICT  = 4'd2,
    ST_FILL   = 4'd3,
    ST_RESP   = 4'd4,
    ST_DONE   = 4'd5
  } state_t;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ddr3_line_cache_ram.sv
// 1R1W synchronous line store holding {tag, line} per index; contents are not reset.
module ddr3_line_ram #(
  parameter int NUM_LINES = 64,
  parameter int IDX_W     = 6,
  parameter int LINE_W    = 256,
  parameter int TAG_W     = 21
) (
  input  logic              i_clk,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [TAG_W-1:0]  o_rtag,
  output logic [LINE_W-1:0] o_rline,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [LINE_W-1:0] i_wline
);

  logic [TAG_W+LINE_W-1:0] r_mem [NUM_LINES];
  logic [TAG_W+LINE_W-1:0] r_rd;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= {i_wtag, i_wline};
    r_rd <= r_mem[i_raddr];
  end

  assign {o_rtag, o_rline} = r_rd;

endmodule

// File: rtl/ddr3_line_cache.sv
// Direct-mapped write-back cache between the 32-bit CPU bus and the DDR3 line controller.
// Optional hit/miss counters are built when DDR3_CACHE_STATS_EN is defined.
module ddr3_line_cache
  import ddr3_line_cache_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int NUM_LINES  = 64,
  parameter int MEM_ADDR_W = 29
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             addr_i,
  input  logic [31:0]             data_i,
  input  logic [3:0]              sel_i,
  input  logic                    we_i,
  input  logic                    rd_i,
  output logic [31:0]             data_o,
  output logic                    ack_o,
  output logic [MEM_ADDR_W-1:0]   ctrl_addr_o,
  output logic [32*LINE_WORDS-1:0] ctrl_data_o,
  input  logic [32*LINE_WORDS-1:0] ctrl_data_i,
  output logic                    ctrl_we_o,
  output logic                    ctrl_rd_o,
  input  logic                    ctrl_ack_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o,
  output logic [15:0]             state_value
);

  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int LINE_W = 32 * LINE_WORDS;

  state_t                r_state;
  logic [31:0]           r_addr, r_data_in, r_data_o;
  logic [3:0]            r_sel;
  logic                  r_we_op, r_ack, r_ctrl_we, r_ctrl_rd;
  logic [NUM_LINES-1:0]  r_valid, r_dirty;
  logic [MEM_ADDR_W-1:0] r_ctrl_addr;
  logic [LINE_W-1:0]     r_ctrl_data;

  logic [IDX_W-1:0]      w_idx, w_rd_idx;
  logic [TAG_W-1:0]      w_tag, w_rd_tag;
  logic [WOFF_W-1:0]     w_off;
  logic [LINE_W-1:0]     w_rd_line;
  logic [LINE_WORDS-1:0][31:0] w_src_words, w_merged_words;
  logic [31:0]           w_word;
  logic                  w_hit, w_ram_we;
  logic [LINE_W-1:0]     w_ram_wline;
  logic [29:0]           w_new_full, w_old_full;
  logic                  w_unused;

  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_tag = r_addr[31 -: TAG_W];
  assign w_off = r_addr[2 +: WOFF_W];
  // In IDLE the store is addressed straight from the bus so the line is ready in LOOKUP.
  assign w_rd_idx = (r_state == ST_IDLE) ? addr_i[OFF_W +: IDX_W] : w_idx;

  assign w_new_full = {r_addr[31:OFF_W], {WOFF_W{1'b0}}};
  assign w_old_full = {w_rd_tag, w_idx, {WOFF_W{1'b0}}};
  assign w_unused   = ^{addr_i[1:0], w_new_full, w_old_full};

  ddr3_line_ram #(
    .NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .LINE_W(LINE_W), .TAG_W(TAG_W)
  ) u_ram (
    .i_clk  (clk),
    .i_raddr(w_rd_idx),
    .o_rtag (w_rd_tag),
    .o_rline(w_rd_line),
    .i_we   (w_ram_we),
    .i_waddr(w_idx),
    .i_wtag (w_tag),
    .i_wline(w_ram_wline)
  );

  always_comb begin
    w_src_words    = (r_state == ST_FILL) ? ctrl_data_i : w_rd_line;
    w_word         = w_src_words[w_off];
    w_merged_words = w_src_words;
    w_merged_words[w_off] = merge_word(w_word, r_data_in, r_sel);
    w_hit          = r_valid[w_idx] && (w_rd_tag == w_tag);
    w_ram_wline    = r_we_op ? w_merged_words : w_src_words;
    w_ram_we       = 1'b0;
    if (r_state == ST_LOOKUP && w_hit && r_we_op) w_ram_we = 1'b1;
    if (r_state == ST_FILL && ctrl_ack_i)         w_ram_we = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_data_in   <= '0;
      r_sel       <= '0;
      r_we_op     <= 1'b0;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_data_o    <= '0;
      r_ack       <= 1'b0;
      r_ctrl_we   <= 1'b0;
      r_ctrl_rd   <= 1'b0;
      r_ctrl_addr <= '0;
      r_ctrl_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (we_i || rd_i) begin
          r_addr    <= addr_i;
          r_data_in <= data_i;
          r_sel     <= sel_i;
          r_we_op   <= we_i;
          r_state   <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_ack    <= 1'b1;
            r_data_o <= r_we_op ? 32'd0 : w_word;
            if (r_we_op) r_dirty[w_idx] <= 1'b1;
            r_state  <= ST_RESP;
          end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
            r_ctrl_we   <= 1'b1;
            r_ctrl_addr <= w_old_full[MEM_ADDR_W-1:0];
            r_ctrl_data <= w_rd_line;
            r_state     <= ST_EVICT;
          end else begin
            r_ctrl_rd   <= 1'b1;
            r_ctrl_addr <= w_new_full[MEM_ADDR_W-1:0];
            r_state     <= ST_FILL;
          end
        end
        ST_EVICT: if (ctrl_ack_i) begin
          r_ctrl_we   <= 1'b0;
          r_ctrl_rd   <= 1'b1;
          r_ctrl_addr <= w_new_full[MEM_ADDR_W-1:0];
          r_state     <= ST_FILL;
        end
        ST_FILL: if (ctrl_ack_i) begin
          // Fill and any pending write merge land in the store in one write.
          r_ctrl_rd      <= 1'b0;
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= r_we_op;
          r_ack          <= 1'b1;
          r_data_o       <= r_we_op ? 32'd0 : w_word;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          r_ack    <= 1'b0;
          r_data_o <= '0;
          r_state  <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DDR3_CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == ST_LOOKUP) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`else
  assign hit_cnt_o  = 32'd0;
  assign miss_cnt_o = 32'd0;
`endif

  assign data_o      = r_data_o;
  assign ack_o       = r_ack;
  assign ctrl_addr_o = r_ctrl_addr;
  assign ctrl_data_o = r_ctrl_data;
  assign ctrl_we_o   = r_ctrl_we;
  assign ctrl_rd_o   = r_ctrl_rd;
  assign state_value = {12'd0, r_state};

endmodule

// File: tb/tb_ddr3_line_cache.sv
// Directed bench for ddr3_line_cache (default parameters) with a one-cycle controller responder.
module tb_ddr3_line_cache;

`ifdef DDR3_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr_i, data_i;
  logic [3:0]   sel_i;
  logic         we_i, rd_i;
  logic [31:0]  data_o;
  logic         ack_o;
  logic [28:0]  ctrl_addr_o;
  logic [255:0] ctrl_data_o, ctrl_data_i;
  logic         ctrl_we_o, ctrl_rd_o, ctrl_ack_i;
  logic [31:0]  hit_cnt_o, miss_cnt_o;
  logic [15:0]  state_value;

  int checks = 0;
  int failures = 0;

  logic [31:0]  o_data;
  int           o_cycles;
  logic         o_saw_we, o_saw_rd, o_rd_after_we, o_timeout, o_both;
  logic [28:0]  o_we_addr, o_rd_addr;
  logic [255:0] o_we_data;
  logic [255:0] fill_a, fill_b;
  logic         seen;

  ddr3_line_cache dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
    .we_i(we_i), .rd_i(rd_i), .data_o(data_o), .ack_o(ack_o),
    .ctrl_addr_o(ctrl_addr_o), .ctrl_data_o(ctrl_data_o), .ctrl_data_i(ctrl_data_i),
    .ctrl_we_o(ctrl_we_o), .ctrl_rd_o(ctrl_rd_o), .ctrl_ack_i(ctrl_ack_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .state_value(state_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pattern(input logic [31:0] base);
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = base + i;
    return p;
  endfunction

  // One CPU transaction; answers controller requests one cycle after they appear.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic r, input logic [255:0] fill);
    logic done;
    done = 1'b0;
    o_saw_we = 1'b0; o_saw_rd = 1'b0; o_rd_after_we = 1'b0; o_both = 1'b0;
    o_timeout = 1'b0; o_cycles = 0; o_data = '0;
    o_we_addr = '0; o_rd_addr = '0; o_we_data = '0;
    addr_i = a; data_i = d; sel_i = s; we_i = w; rd_i = r;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk); #1;
      ctrl_ack_i = 1'b0;
      if (ctrl_we_o && ctrl_rd_o) o_both = 1'b1;
      if (ack_o) begin
        o_cycles = c;
        o_data = data_o;
        done = 1'b1;
      end else if (ctrl_we_o) begin
        if (!o_saw_we) begin
          o_saw_we = 1'b1; o_we_addr = ctrl_addr_o; o_we_data = ctrl_data_o;
        end
        ctrl_ack_i = 1'b1;
      end else if (ctrl_rd_o) begin
        if (!o_saw_rd) begin
          o_saw_rd = 1'b1; o_rd_after_we = o_saw_we; o_rd_addr = ctrl_addr_o;
        end
        ctrl_data_i = fill;
        ctrl_ack_i = 1'b1;
      end
    end
    we_i = 1'b0; rd_i = 1'b0; ctrl_ack_i = 1'b0;
    if (!done) o_timeout = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr_i = '0; data_i = '0; sel_i = '0; we_i = 1'b0; rd_i = 1'b0;
    ctrl_data_i = '0; ctrl_ack_i = 1'b0;
    fill_a = pattern(32'hA5A5_0000);
    fill_b = pattern(32'h5A5A_0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 256'(ack_o), 256'(1'b0));
    chk("rst_data", 256'(data_o), 256'(32'd0));
    chk("rst_ctrl_we", 256'(ctrl_we_o), 256'(1'b0));
    chk("rst_ctrl_rd", 256'(ctrl_rd_o), 256'(1'b0));
    chk("rst_state", 256'(state_value), 256'(16'd0));
    chk("rst_hits", 256'(hit_cnt_o), 256'(32'd0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold read miss: clean fill of line idx 2.
    access(32'h0000_0040, 32'd0, 4'h0, 1'b0, 1'b1, fill_a);
    chk("s1_timeout", 256'(o_timeout), 256'(1'b0));
    chk("s1_data", 256'(o_data), 256'(32'hA5A5_0000));
    chk("s1_rd_addr", 256'(o_rd_addr), 256'(29'h10));
    chk("s1_no_evict", 256'(o_saw_we), 256'(1'b0));
    chk("s1_latency", 256'(o_cycles), 256'(3));
    chk("s1_miss_cnt", 256'(miss_cnt_o), 256'(STATS ? 32'd1 : 32'd0));

    access(32'h0000_0044, 32'd0, 4'h0, 1'b0, 1'b1, fill_b);
    chk("s2_data", 256'(o_data), 256'(32'hA5A5_0001));
    chk("s2_latency", 256'(o_cycles), 256'(2));
    chk("s2_no_ctrl", 256'({o_saw_we, o_saw_rd}), 256'(2'b00));
    chk("s2_hit_cnt", 256'(hit_cnt_o), 256'(STATS ? 32'd1 : 32'd0));

    // Byte-lane write hit, then read back the merged word.
    access(32'h0000_0040, 32'h1122_3344, 4'b0011, 1'b1, 1'b0, fill_b);
    chk("s3_wr_latency", 256'(o_cycles), 256'(2));
    chk("s3_wr_no_ctrl", 256'({o_saw_we, o_saw_rd}), 256'(2'b00));
    access(32'h0000_0040, 32'd0, 4'h0, 1'b0, 1'b1, fill_b);
    chk("s3_merged", 256'(o_data), 256'(32'hA5A5_3344));

    // Conflicting tag on dirty line: evict then fill.
    access(32'h0000_0840, 32'd0, 4'h0, 1'b0, 1'b1, fill_b);
    chk("s4_evict_seen", 256'(o_saw_we), 256'(1'b1));
    chk("s4_evict_first", 256'(o_rd_after_we), 256'(1'b1));
    chk("s4_evict_addr", 256'(o_we_addr), 256'(29'h10));
    chk("s4_evict_w0", 256'(o_we_data[31:0]), 256'(32'hA5A5_3344));
    chk("s4_evict_w1", 256'(o_we_data[63:32]), 256'(32'hA5A5_0001));
    chk("s4_fill_addr", 256'(o_rd_addr), 256'(29'h210));
    chk("s4_data", 256'(o_data), 256'(32'h5A5A_0000));
    chk("s4_latency", 256'(o_cycles), 256'(4));
    chk("s4_never_both", 256'(o_both), 256'(1'b0));

    // Empty byte-enable write: data unchanged but line becomes dirty.
    access(32'h0000_0844, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0, fill_b);
    chk("s5_sel0_ack", 256'(o_timeout), 256'(1'b0));
    access(32'h0000_0844, 32'd0, 4'h0, 1'b0, 1'b1, fill_b);
    chk("s5_sel0_data", 256'(o_data), 256'(32'h5A5A_0001));
    access(32'h0000_0044, 32'd0, 4'h0, 1'b0, 1'b1, fill_a);
    chk("s5_dirty_evict", 256'(o_saw_we), 256'(1'b1));
    chk("s5_evict_addr", 256'(o_we_addr), 256'(29'h210));
    chk("s5_evict_w1", 256'(o_we_data[63:32]), 256'(32'h5A5A_0001));
    chk("s5_data", 256'(o_data), 256'(32'hA5A5_0001));

    // we_i and rd_i together behave as a write.
    access(32'h0000_0048, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b1, fill_b);
    chk("s6_both_latency", 256'(o_cycles), 256'(2));
    access(32'h0000_0048, 32'd0, 4'h0, 1'b0, 1'b1, fill_b);
    chk("s6_both_wrote", 256'(o_data), 256'(32'hDEAD_BEEF));
    chk("s6_hit_cnt", 256'(hit_cnt_o), 256'(STATS ? 32'd7 : 32'd0));
    chk("s6_miss_cnt", 256'(miss_cnt_o), 256'(STATS ? 32'd3 : 32'd0));

    // Reset while the fill request is outstanding.
    seen = 1'b0;
    addr_i = 32'h0000_1000; rd_i = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (ctrl_rd_o) seen = 1'b1;
    end
    chk("s7_fill_req", 256'(seen), 256'(1'b1));
    rst = 1'b1;
    #1;
    chk("s7_rd_drop", 256'(ctrl_rd_o), 256'(1'b0));
    chk("s7_state", 256'(state_value), 256'(16'd0));
    rd_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    access(32'h0000_0048, 32'd0, 4'h0, 1'b0, 1'b1, fill_a);
    chk("s7_miss_after_rst", 256'(o_saw_rd), 256'(1'b1));
    chk("s7_no_evict", 256'(o_saw_we), 256'(1'b0));
    chk("s7_data", 256'(o_data), 256'(32'hA5A5_0002));
    chk("s7_miss_cnt", 256'(miss_cnt_o), 256'(STATS ? 32'd1 : 32'd0));
    chk("s7_hit_cnt", 256'(hit_cnt_o), 256'(32'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
